mcu_block_scheduler: RTL and testbench

- Sequences component order for the entropy decoder across each MCU of a frame.
- Drives the expected component index and Huffman table select to the decoder.
- Tags each decoded 8x8 block with component, MCU-last and frame-last flags, and applies backpressure from the downstream dequant/IDCT stage to the decoder.
- Carries only control/tags; block coefficients bypass this block.

---
 rtl/mcu_block_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_mcu_block_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_block_scheduler.sv
// MCU block scheduler: sequences Y/Cb/Cr block order for the entropy decoder,
// tags each decoded block for the dequant/IDCT stage and relays backpressure.
module mcu_block_scheduler #(
  parameter int unsigned CH    = 3,
  parameter int unsigned CHW   = $clog2(CH + 1),
  parameter int unsigned MCU_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MCU_W-1:0] num_mcus,
  input  logic [2:0]       y_blocks,
  input  logic [CH-1:0]    map_cfg,
  input  logic             dec_valid,
  input  logic [CHW-1:0]   dec_ch,
  output logic             dec_hold,
  output logic [CHW-1:0]   exp_ch,
  output logic             tab_sel,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [CHW-1:0]   blk_ch,
  output logic             blk_last_mcu,
  output logic             blk_last_frame,
  output logic             busy,
  output logic             frame_done,
  output logic             seq_err
);

  // Block index within an MCU spans 0..y_blocks+1, at most 5.
  localparam int unsigned IDXW = 3;
  localparam int unsigned YW   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   blk_idx_q, blk_idx_d;
  logic [MCU_W-1:0]  mcu_cnt_q, mcu_cnt_d;
  logic [MCU_W-1:0]  num_q, num_d;
  logic [YW-1:0]     ycfg_q, ycfg_d;
  logic [CH-1:0]     map_q, map_d;
  logic [CHW-1:0]    exp_ch_q, exp_ch_d;
  logic              blk_valid_q, blk_valid_d;
  logic [CHW-1:0]    blk_ch_q, blk_ch_d;
  logic              blk_last_mcu_q, blk_last_mcu_d;
  logic              blk_last_frame_q, blk_last_frame_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              seq_err_q, seq_err_d;

  logic              y_legal;
  logic              start_go;
  logic              start_empty;
  logic              slot_free;
  logic              handoff;
  logic              accept;
  logic              last_in_mcu;
  logic              last_mcu_of_frame;
  logic              frame_last;

  // Component owning block slot idx of an MCU with y luma blocks.
  function automatic logic [CHW-1:0] ch_of(input logic [IDXW-1:0] idx,
                                           input logic [YW-1:0]   y);
    logic [CHW-1:0] ch;
    ch = CHW'(2);
    if (idx < IDXW'(y)) begin
      ch = CHW'(0);
    end else if (idx == IDXW'(y)) begin
      ch = CHW'(1);
    end
    return ch;
  endfunction

  // Shared decode of handshake and sequence-position conditions.
  always_comb begin
    y_legal           = (y_blocks == 3'd1) || (y_blocks == 3'd2) || (y_blocks == 3'd4);
    start_go          = (state_q == S_IDLE) && start && y_legal && (num_mcus != '0);
    start_empty       = (state_q == S_IDLE) && start && y_legal && (num_mcus == '0);
    slot_free         = !blk_valid_q || blk_ready;
    handoff           = blk_valid_q && blk_ready;
    accept            = (state_q == S_RUN) && dec_valid && slot_free;
    last_in_mcu       = (blk_idx_q == (IDXW'(ycfg_q) + IDXW'(1)));
    last_mcu_of_frame = (mcu_cnt_q == (num_q - MCU_W'(1)));
    frame_last        = last_in_mcu && last_mcu_of_frame;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && frame_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (handoff && blk_last_frame_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, config, tag and status next values.
  always_comb begin
    blk_idx_d        = blk_idx_q;
    mcu_cnt_d        = mcu_cnt_q;
    num_d            = num_q;
    ycfg_d           = ycfg_q;
    map_d            = map_q;
    blk_valid_d      = blk_valid_q;
    blk_ch_d         = blk_ch_q;
    blk_last_mcu_d   = blk_last_mcu_q;
    blk_last_frame_d = blk_last_frame_q;
    seq_err_d        = seq_err_q;
    exp_ch_d         = CHW'(0);
    busy_d           = 1'b0;
    frame_done_d     = 1'b0;

    // Frame setup: latch config and rewind the sequence.
    if (start_go) begin
      num_d     = num_mcus;
      ycfg_d    = y_blocks;
      map_d     = map_cfg;
      blk_idx_d = '0;
      mcu_cnt_d = '0;
    end

    // Sequence advance on each accepted block.
    if (accept) begin
      if (last_in_mcu) begin
        blk_idx_d = '0;
        mcu_cnt_d = frame_last ? '0 : (mcu_cnt_q + MCU_W'(1));
      end else begin
        blk_idx_d = blk_idx_q + IDXW'(1);
      end
    end

    // Tag slot: load on accept, otherwise empty it once handed off.
    if (accept) begin
      blk_valid_d      = 1'b1;
      blk_ch_d         = exp_ch_q;
      blk_last_mcu_d   = last_in_mcu;
      blk_last_frame_d = frame_last;
    end else if (handoff) begin
      blk_valid_d      = 1'b0;
      blk_ch_d         = CHW'(0);
      blk_last_mcu_d   = 1'b0;
      blk_last_frame_d = 1'b0;
    end

    // Error flag: clear on a legal start in IDLE, then apply any new fault.
    if ((state_q == S_IDLE) && start) begin
      seq_err_d = !y_legal;
    end
    if (dec_valid) begin
      if (state_q != S_RUN) begin
        seq_err_d = 1'b1;
      end else if (!slot_free) begin
        seq_err_d = 1'b1;
      end else if (dec_ch != exp_ch_q) begin
        seq_err_d = 1'b1;
      end
    end

    if (state_d == S_RUN) begin
      exp_ch_d = ch_of(blk_idx_d, ycfg_d);
    end
    busy_d       = (state_d != S_IDLE);
    frame_done_d = ((state_q == S_DRAIN) && handoff && blk_last_frame_q) || start_empty;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_idx_q        <= '0;
      mcu_cnt_q        <= '0;
      num_q            <= '0;
      ycfg_q           <= '0;
      map_q            <= '0;
      exp_ch_q         <= '0;
      blk_valid_q      <= 1'b0;
      blk_ch_q         <= '0;
      blk_last_mcu_q   <= 1'b0;
      blk_last_frame_q <= 1'b0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      seq_err_q        <= 1'b0;
    end else begin
      blk_idx_q        <= blk_idx_d;
      mcu_cnt_q        <= mcu_cnt_d;
      num_q            <= num_d;
      ycfg_q           <= ycfg_d;
      map_q            <= map_d;
      exp_ch_q         <= exp_ch_d;
      blk_valid_q      <= blk_valid_d;
      blk_ch_q         <= blk_ch_d;
      blk_last_mcu_q   <= blk_last_mcu_d;
      blk_last_frame_q <= blk_last_frame_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      seq_err_q        <= seq_err_d;
    end
  end

  // Output drive; stall and table select follow live state directly.
  always_comb begin
    dec_hold       = blk_valid_q && !blk_ready;
    exp_ch         = exp_ch_q;
    tab_sel        = map_q[exp_ch_q];
    blk_valid      = blk_valid_q;
    blk_ch         = blk_ch_q;
    blk_last_mcu   = blk_last_mcu_q;
    blk_last_frame = blk_last_frame_q;
    busy           = busy_q;
    frame_done     = frame_done_q;
    seq_err        = seq_err_q;
  end

endmodule

// File: tb/tb_mcu_block_scheduler.sv
// Bench for mcu_block_scheduler: list-based frame model checked every cycle,
// plus literal tag/flag sequences per directed scenario.
module tb_mcu_block_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_mcus;
  logic [2:0]  y_blocks;
  logic [2:0]  map_cfg;
  logic        dec_valid;
  logic [1:0]  dec_ch;
  logic        dec_hold;
  logic [1:0]  exp_ch;
  logic        tab_sel;
  logic        blk_valid;
  logic        blk_ready;
  logic [1:0]  blk_ch;
  logic        blk_last_mcu;
  logic        blk_last_frame;
  logic        busy;
  logic        frame_done;
  logic        seq_err;

  mcu_block_scheduler #(.CH(3), .CHW(2), .MCU_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_mcus(num_mcus),
    .y_blocks(y_blocks), .map_cfg(map_cfg), .dec_valid(dec_valid),
    .dec_ch(dec_ch), .dec_hold(dec_hold), .exp_ch(exp_ch), .tab_sel(tab_sel),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_ch(blk_ch),
    .blk_last_mcu(blk_last_mcu), .blk_last_frame(blk_last_frame),
    .busy(busy), .frame_done(frame_done), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  // ---------------- frame model ----------------
  typedef struct packed { logic [1:0] ch; logic lm; logic lf; } tag_t;
  tag_t       blist[$];
  int         k;
  int         m_state;   // 0 idle, 1 run, 2 drain
  logic       m_valid;
  tag_t       m_tag;
  logic       m_err;
  logic       m_fd;
  logic [2:0] m_map;
  logic [1:0] m_exp;

  // Full ordered block list of a frame straight from the MCU layout rule.
  task automatic build(input int y, input int n);
    tag_t t;
    blist.delete();
    for (int m = 0; m < n; m++) begin
      for (int b = 0; b < y + 2; b++) begin
        t.ch = (b < y) ? 2'd0 : ((b == y) ? 2'd1 : 2'd2);
        t.lm = (b == y + 1);
        t.lf = (b == y + 1) && (m == n - 1);
        blist.push_back(t);
      end
    end
  endtask

  always @(posedge clk) begin : model
    logic handoff, sfree, acc;
    if (!rst) begin
      m_state = 0; m_valid = 0; m_tag = '0; m_err = 0; m_fd = 0; m_map = '0; k = 0;
      blist.delete();
    end else begin
      handoff = m_valid && blk_ready;
      sfree   = !m_valid || blk_ready;
      acc     = 0;
      m_fd    = 0;
      case (m_state)
        0: begin
          if (start) begin
            if (!(y_blocks == 3'd1 || y_blocks == 3'd2 || y_blocks == 3'd4)) m_err = 1;
            else begin
              m_err = 0;
              if (num_mcus == 0) m_fd = 1;
              else begin
                build(int'(y_blocks), int'(num_mcus));
                m_map = map_cfg; k = 0; m_state = 1;
              end
            end
          end
          if (dec_valid) m_err = 1;
        end
        1: begin
          if (dec_valid) begin
            if (sfree) begin
              acc = 1;
              if (dec_ch != blist[k].ch) m_err = 1;
              m_tag = blist[k];
              k++;
              if (k == blist.size()) m_state = 2;
            end else m_err = 1;
          end
        end
        default: begin
          if (dec_valid) m_err = 1;
          if (handoff && m_tag.lf) begin m_state = 0; m_fd = 1; end
        end
      endcase
      if (acc) m_valid = 1;
      else if (handoff) m_valid = 0;
    end
    m_exp = (m_state == 1) ? blist[k].ch : 2'd0;
  end

  // Per-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    chk("busy", busy, 32'(m_state != 0));
    chk("frame_done", frame_done, 32'(m_fd));
    chk("seq_err", seq_err, 32'(m_err));
    chk("exp_ch", exp_ch, 32'(m_exp));
    chk("tab_sel", tab_sel, 32'(m_map[m_exp]));
    chk("blk_valid", blk_valid, 32'(m_valid));
    chk("dec_hold", dec_hold, 32'(m_valid && !blk_ready));
    if (m_valid) chk("blk_tag", {blk_ch, blk_last_mcu, blk_last_frame}, 32'(m_tag));
  end

  // ---------------- observation monitors ----------------
  int   tag_log[$];
  int   tsel_log[$];
  int   fd_cnt;
  logic busy_seen;
  initial begin fd_cnt = 0; busy_seen = 0; end

  always @(posedge clk) begin
    if (rst && blk_valid && blk_ready) tag_log.push_back(int'({blk_ch, blk_last_mcu, blk_last_frame}));
    if (rst && dec_valid && !dec_hold && busy) tsel_log.push_back(int'(tab_sel));
    if (rst && frame_done) fd_cnt++;
    if (busy) busy_seen = 1;
  end

  task automatic chk_log(input string nm, input int q[$], input int e[8], input int n);
    chk({nm, "_count"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++)
      chk($sformatf("%s_%0d", nm, i), 32'(q[i]), 32'(e[i]));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic [2:0] y, input logic [15:0] n, input logic [2:0] map);
    @(negedge clk);
    y_blocks = y; num_mcus = n; map_cfg = map; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed correct blocks every cycle while the frame is running, then let it drain.
  task automatic stream(input int maxc);
    int c;
    c = 0;
    while (c < maxc && m_state != 0) begin
      dec_valid = (m_state == 1);
      dec_ch    = m_exp;
      @(negedge clk);
      c++;
    end
    dec_valid = 1'b0;
    chk("stream_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int e[8];
    int fd0, hc;
    rst = 0; start = 0; num_mcus = 0; y_blocks = 0; map_cfg = 0;
    dec_valid = 0; dec_ch = 0; blk_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_blk_valid", 32'(blk_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_exp_ch", 32'(exp_ch), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    rst = 1;
    @(negedge clk);

    // 1: 4:4:4, two MCUs, full throughput
    tag_log.delete(); fd0 = fd_cnt;
    start_frame(3'd1, 16'd2, 3'b000);
    stream(100);
    e = '{0, 4, 10, 0, 4, 11, 0, 0};
    chk_log("t1_tags", tag_log, e, 6);
    chk("t1_frame_done", 32'(fd_cnt - fd0), 1);

    // 2: 4:2:0, one MCU, table map 110
    tag_log.delete(); tsel_log.delete(); fd0 = fd_cnt;
    start_frame(3'd4, 16'd1, 3'b110);
    stream(100);
    e = '{0, 0, 0, 0, 4, 11, 0, 0};
    chk_log("t2_tags", tag_log, e, 6);
    e = '{0, 0, 0, 0, 1, 1, 0, 0};
    chk_log("t2_tsel", tsel_log, e, 6);
    chk("t2_frame_done", 32'(fd_cnt - fd0), 1);
    chk("t2_busy", 32'(busy), 0);

    // 3: backpressure for 5 cycles after the first tag
    tag_log.delete(); hc = 0;
    start_frame(3'd1, 16'd1, 3'b000);
    dec_valid = 1; dec_ch = m_exp;
    @(negedge clk);
    dec_valid = 0; blk_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dec_hold && blk_ch == 2'd0) hc++;
    end
    chk("t3_hold_cycles", 32'(hc), 5);
    @(negedge clk);
    blk_ready = 1;
    stream(100);
    e = '{0, 4, 11, 0, 0, 0, 0, 0};
    chk_log("t3_tags", tag_log, e, 3);
    chk("t3_seq_err", 32'(seq_err), 0);

    // 4a: wrong component on the first block
    tag_log.delete();
    start_frame(3'd1, 16'd1, 3'b000);
    dec_valid = 1; dec_ch = 2'd2;
    @(negedge clk);
    stream(100);
    e = '{0, 4, 11, 0, 0, 0, 0, 0};
    chk_log("t4a_tags", tag_log, e, 3);
    chk("t4a_seq_err", 32'(seq_err), 1);
    repeat (3) @(negedge clk);
    chk("t4a_seq_err_sticky", 32'(seq_err), 1);

    // 4b: strobe while stalled is dropped
    tag_log.delete();
    start_frame(3'd1, 16'd1, 3'b000);
    chk("t4b_err_cleared", 32'(seq_err), 0);
    dec_valid = 1; dec_ch = m_exp;
    @(negedge clk);
    blk_ready = 0; dec_valid = 1; dec_ch = m_exp;
    @(negedge clk);
    blk_ready = 1;
    stream(100);
    e = '{0, 4, 11, 0, 0, 0, 0, 0};
    chk_log("t4b_tags", tag_log, e, 3);
    chk("t4b_seq_err", 32'(seq_err), 1);

    // 5a: empty frame
    busy_seen = 0; fd0 = fd_cnt;
    start_frame(3'd1, 16'd0, 3'b000);
    @(negedge clk);
    chk("t5a_frame_done", 32'(fd_cnt - fd0), 1);
    chk("t5a_busy_seen", 32'(busy_seen), 0);

    // 5b: illegal luma count
    start_frame(3'd3, 16'd1, 3'b000);
    chk("t5b_seq_err", 32'(seq_err), 1);
    chk("t5b_busy", 32'(busy), 0);

    // 5c: start while running is ignored
    tag_log.delete();
    start_frame(3'd1, 16'd2, 3'b000);
    dec_valid = 1; dec_ch = m_exp;
    @(negedge clk);
    dec_ch = m_exp;
    @(negedge clk);
    start = 1; num_mcus = 16'd5; y_blocks = 3'd2; dec_ch = m_exp;
    @(negedge clk);
    start = 0;
    stream(100);
    e = '{0, 4, 10, 0, 4, 11, 0, 0};
    chk_log("t5c_tags", tag_log, e, 6);

    // 6: reset mid-frame with a tag pending
    fd0 = fd_cnt;
    start_frame(3'd1, 16'd2, 3'b000);
    dec_valid = 1; dec_ch = m_exp;
    @(negedge clk);
    dec_ch = m_exp;
    @(negedge clk);
    dec_valid = 0; blk_ready = 0; rst = 0;
    @(posedge clk); #1;
    chk("t6_blk_valid", 32'(blk_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_exp_ch", 32'(exp_ch), 0);
    chk("t6_dec_hold", 32'(dec_hold), 0);
    @(negedge clk);
    rst = 1; blk_ready = 1;
    @(negedge clk);
    chk("t6_no_frame_done", 32'(fd_cnt - fd0), 0);
    tag_log.delete();
    start_frame(3'd1, 16'd1, 3'b000);
    stream(100);
    e = '{0, 4, 11, 0, 0, 0, 0, 0};
    chk_log("t6_tags", tag_log, e, 3);
    chk("t6_seq_err", 32'(seq_err), 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
